// File: rtl/adc_capture_pkg.sv
// Shared constants and writer state encoding for the
// ADC sample capture to SDRAM write path.
package adc_capture_pkg;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DATA_W = 16;

    // The writer only ever issues write requests.
    localparam logic WNR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_WAIT = 2'd2
    } wr_state_e;

endpackage

// File: rtl/adc_sdram_writer_if.sv
// Request/response bundle between the capture writer
// and the SDRAM controller.
interface adc_sdram_writer_if
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              Req;
    logic              WnR;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic              Busy;
    logic              Ack;

    modport master (
        output Req, WnR, Address, DataIn,
        input  Busy, Ack
    );

    modport slave (
        input  Req, WnR, Address, DataIn,
        output Busy, Ack
    );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample buffer.
// Full/empty come from the registered occupancy.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Occupancy: push and pop together leave it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Sample storage; contents need no reset.
    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/adc_sdram_writer.sv
// Captures a programmed number of ADC samples and drains
// them as single-word SDRAM writes at rising addresses.
module adc_sdram_writer
    import adc_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic [ADDR_W-1:0]           BaseAddr,
    input  logic [ADDR_W-1:0]           CaptureLen,
    input  logic [DATA_W-1:0]           SampleData,
    input  logic                        SampleValid,
    output logic                        Capturing,
    output logic                        Done,
    output logic                        Overflow,
    output logic [$clog2(FIFO_DEPTH):0] FillLevel,
    adc_sdram_writer_if.master          ctrl
);

    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
    logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cap_q, cap_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              req_q, req_d;
    wr_state_e         st_q, st_d;

    logic              start_ok;
    logic              want;
    logic              push;
    logic              drop;
    logic              pop;
    logic              acked;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    assign start_ok = Start & ~cap_q;
    assign want     = SampleValid & cap_q & (in_cnt_q < len_q);
    assign push     = want & ~fifo_full;
    assign drop     = want & fifo_full;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (SampleData),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (FillLevel)
    );

    // Capture bookkeeping: dropped samples count as written
    // so a capture always terminates after len samples.
    always_comb begin
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q + ADDR_W'(acked) + ADDR_W'(drop);
        cap_d     = cap_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        if (push | drop) in_cnt_d = in_cnt_q + ADDR_W'(1);
        if (drop)        ovf_d    = 1'b1;
        if (cap_q && out_cnt_q == len_q && fifo_empty) begin
            done_d = 1'b1;
            cap_d  = 1'b0;
        end
        if (start_ok) begin
            len_d     = CaptureLen;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            ovf_d     = 1'b0;
            cap_d     = (CaptureLen != '0);
            done_d    = (CaptureLen == '0);
        end
    end

    // Writer FSM: one request per FIFO word, never while Busy.
    always_comb begin
        st_d      = st_q;
        req_d     = req_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_addr_d = wr_addr_q;
        pop       = 1'b0;
        acked     = 1'b0;
        case (st_q)
            W_IDLE: begin
                if (!fifo_empty && !ctrl.Busy) begin
                    data_d = head;
                    addr_d = wr_addr_q;
                    req_d  = 1'b1;
                    pop    = 1'b1;
                    st_d   = W_REQ;
                end
            end
            W_REQ: begin
                if (ctrl.Ack) begin
                    req_d     = 1'b0;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    acked     = 1'b1;
                    st_d      = W_WAIT;
                end
            end
            W_WAIT: begin
                if (!ctrl.Busy) st_d = W_IDLE;
            end
            default: begin
                st_d  = W_IDLE;
                req_d = 1'b0;
            end
        endcase
        if (start_ok) wr_addr_d = BaseAddr;
    end

    // State registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_addr_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            cap_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            req_q     <= 1'b0;
            st_q      <= W_IDLE;
        end else begin
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wr_addr_q <= wr_addr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cap_q     <= cap_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            req_q     <= req_d;
            st_q      <= st_d;
        end
    end

    assign Capturing    = cap_q;
    assign Done         = done_q;
    assign Overflow     = ovf_q;
    assign ctrl.Req     = req_q;
    assign ctrl.WnR     = WNR_WRITE;
    assign ctrl.Address = addr_q;
    assign ctrl.DataIn  = data_q;

endmodule

// File: tb/tb_adc_sdram_writer.sv
// Bench for adc_sdram_writer: controller model acks each
// request; a scoreboard holds the expected address/data.
module tb_adc_sdram_writer;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [21:0] BaseAddr;
    logic [21:0] CaptureLen;
    logic [15:0] SampleData;
    logic        SampleValid;
    logic        Capturing;
    logic        Done;
    logic        Overflow;
    logic [4:0]  FillLevel;

    adc_sdram_writer_if #(.ADDR_W(22), .DATA_W(16)) bus ();

    adc_sdram_writer #(
        .FIFO_DEPTH (16),
        .ADDR_W     (22),
        .DATA_W     (16)
    ) dut (
        .Clk         (clk),
        .Reset       (Reset),
        .Start       (Start),
        .BaseAddr    (BaseAddr),
        .CaptureLen  (CaptureLen),
        .SampleData  (SampleData),
        .SampleValid (SampleValid),
        .Capturing   (Capturing),
        .Done        (Done),
        .Overflow    (Overflow),
        .FillLevel   (FillLevel),
        .ctrl        (bus.master)
    );

    int          tests_run = 0;
    int          failures  = 0;
    int          done_cnt  = 0;
    int          req_cnt   = 0;
    bit          ack_en    = 1'b1;
    logic [37:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller model: ack each request one cycle after Req.
    initial begin
        bus.Ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.Ack) bus.Ack = 1'b0;
            else if (bus.Req === 1'b1 && ack_en) bus.Ack = 1'b1;
        end
    end

    // Monitor: every new request is checked against the scoreboard.
    initial begin
        logic        prev_req;
        logic [37:0] e;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (Done === 1'b1) done_cnt++;
            if (bus.Req === 1'b1 && !prev_req) begin
                req_cnt++;
                tests_run++;
                if (bus.Busy !== 1'b0 || bus.WnR !== 1'b1) begin
                    failures++;
                    $display("FAIL req_cond busy=%b wnr=%b need 0/1",
                             bus.Busy, bus.WnR);
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req addr=%h data=%h",
                             bus.Address, bus.DataIn);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.Address, bus.DataIn} !== e) begin
                        failures++;
                        $display("FAIL write addr=%h data=%h need %h/%h",
                                 bus.Address, bus.DataIn,
                                 e[37:16], e[15:0]);
                    end
                end
            end
            prev_req = (bus.Req === 1'b1);
        end
    end

    task automatic pulse_start(input logic [21:0] b,
                               input logic [21:0] l);
        BaseAddr   = b;
        CaptureLen = l;
        Start      = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d0, input int n,
                        input logic [21:0] base, input int n_exp);
        for (int i = 0; i < n; i++) begin
            SampleData  = d0 + 16'(i);
            SampleValid = 1'b1;
            if (i < n_exp)
                exp_q.push_back({base + 22'(i), d0 + 16'(i)});
            @(negedge clk);
        end
        SampleValid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((done_cnt == 0 || Capturing) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        tests_run++;
        if (done_cnt != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_done pulses=%0d left=%0d need 1/0",
                     name, done_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        Start       = 1'b0;
        BaseAddr    = '0;
        CaptureLen  = '0;
        SampleData  = '0;
        SampleValid = 1'b0;
        bus.Busy    = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({Capturing, Done, Overflow} !== 3'b000) begin
            failures++;
            $display("FAIL rst_flags got %b need 000",
                     {Capturing, Done, Overflow});
        end
        tests_run++;
        if (FillLevel !== 5'd0) begin
            failures++;
            $display("FAIL rst_fill got %0d need 0", FillLevel);
        end
        tests_run++;
        if (bus.Req !== 1'b0 || bus.WnR !== 1'b1) begin
            failures++;
            $display("FAIL rst_req req=%b wnr=%b need 0/1",
                     bus.Req, bus.WnR);
        end
        tests_run++;
        if (bus.Address !== 22'd0 || bus.DataIn !== 16'd0) begin
            failures++;
            $display("FAIL rst_bus addr=%h data=%h need 0/0",
                     bus.Address, bus.DataIn);
        end
        Reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        done_cnt = 0;
        pulse_start(22'h000100, 22'd4);
        feed(16'hA000, 4, 22'h000100, 4);
        wait_done("basic");
        tests_run++;
        if (Overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_ovf got %b need 0", Overflow);
        end
    endtask

    task automatic test_busy_stall();
        int r0;
        done_cnt = 0;
        bus.Busy = 1'b1;
        r0 = req_cnt;
        pulse_start(22'h002000, 22'd20);
        feed(16'hB000, 20, 22'h002000, 16);
        tests_run++;
        if (FillLevel !== 5'd16 || Overflow !== 1'b1) begin
            failures++;
            $display("FAIL stall_fill fill=%0d ovf=%b need 16/1",
                     FillLevel, Overflow);
        end
        repeat (18) @(negedge clk);
        tests_run++;
        if (req_cnt != r0 || Capturing !== 1'b1) begin
            failures++;
            $display("FAIL stall_req reqs=%0d cap=%b need 0/1",
                     req_cnt - r0, Capturing);
        end
        bus.Busy = 1'b0;
        wait_done("stall");
        tests_run++;
        if (Overflow !== 1'b1 || req_cnt - r0 != 16) begin
            failures++;
            $display("FAIL stall_end ovf=%b reqs=%0d need 1/16",
                     Overflow, req_cnt - r0);
        end
    endtask

    task automatic test_wrap();
        done_cnt = 0;
        pulse_start(22'h3FFFFE, 22'd4);
        feed(16'hC000, 4, 22'h3FFFFE, 4);
        wait_done("wrap");
    endtask

    task automatic test_len_zero();
        int r0;
        done_cnt = 0;
        r0 = req_cnt;
        pulse_start(22'h001234, 22'd0);
        tests_run++;
        if (Done !== 1'b1 || Capturing !== 1'b0) begin
            failures++;
            $display("FAIL len0_done done=%b cap=%b need 1/0",
                     Done, Capturing);
        end
        @(negedge clk);
        tests_run++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL len0_pulse done=%b need 0", Done);
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (req_cnt != r0 || done_cnt != 1) begin
            failures++;
            $display("FAIL len0_quiet reqs=%0d dones=%0d need 0/1",
                     req_cnt - r0, done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        done_cnt = 0;
        pulse_start(22'h000500, 22'd6);
        for (int i = 0; i < 6; i++) begin
            SampleData  = 16'hE000 + 16'(i);
            SampleValid = 1'b1;
            Start       = (i == 2);
            if (i == 2) begin
                BaseAddr   = 22'h009000;
                CaptureLen = 22'd2;
            end
            exp_q.push_back({22'h000500 + 22'(i), 16'hE000 + 16'(i)});
            @(negedge clk);
        end
        SampleValid = 1'b0;
        Start       = 1'b0;
        wait_done("restart");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        done_cnt = 0;
        bus.Busy = 1'b1;
        pulse_start(22'h000700, 22'd20);
        feed(16'hD000, 18, 22'h000700, 1);
        tests_run++;
        if (Overflow !== 1'b1) begin
            failures++;
            $display("FAIL rmid_ovf got %b need 1", Overflow);
        end
        ack_en   = 1'b0;
        bus.Busy = 1'b0;
        while (bus.Req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (bus.Req !== 1'b1) begin
            failures++;
            $display("FAIL rmid_req got %b need 1", bus.Req);
        end
        Reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.Req !== 1'b0 || FillLevel !== 5'd0) begin
            failures++;
            $display("FAIL rmid_clr req=%b fill=%0d need 0/0",
                     bus.Req, FillLevel);
        end
        tests_run++;
        if (Capturing !== 1'b0 || Overflow !== 1'b0) begin
            failures++;
            $display("FAIL rmid_flags cap=%b ovf=%b need 0/0",
                     Capturing, Overflow);
        end
        Reset  = 1'b0;
        ack_en = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_wrap();
        test_len_zero();
        test_restart_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/adc_sdram_writer.md
Name: adc_sdram_writer

Overview:
Upstream feeder for the SDRAM controller. Captures a programmed number of 16-bit ADC samples into a small FIFO and drains them as single-word SDRAM write requests at incrementing addresses. It drives the controller's Req/WnR/Address/DataIn inputs and consumes its Busy/Ack outputs. The FIFO decouples the ADC sample rate from controller stalls such as refresh and init.

Parameters:
FIFO_DEPTH, 16, sample buffer depth in words (power of 2, at least 4)
ADDR_W, 22, SDRAM word-address width
DATA_W, 16, sample/SDRAM data width

Ports:
Clk  in  1  system clock (100 MHz), all logic on rising edge
Reset  in  1  synchronous, active-high
Start  in  1  one-cycle pulse: begin capture; ignored while Capturing=1
BaseAddr  in  ADDR_W  first SDRAM address, sampled on Start
CaptureLen  in  ADDR_W  number of samples to capture, sampled on Start
SampleData  in  DATA_W  ADC sample
SampleValid  in  1  SampleData valid this cycle
Capturing  out  1  capture in progress
Done  out  1  one-cycle pulse after the last word is acknowledged
Overflow  out  1  sticky: a valid sample was dropped because the FIFO was full
FillLevel  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
Req  out  1  to controller Req
WnR  out  1  to controller WnR, constant 1
Address  out  ADDR_W  to controller Address
DataIn  out  DATA_W  to controller DataIn
Busy  in  1  from controller Busy
Ack  in  1  from controller Ack

Behaviour:
- Reset: Capturing=0, Done=0, Overflow=0, FillLevel=0, Req=0, WnR=1, Address=0, DataIn=0. FIFO emptied, counters cleared, writer FSM to W_IDLE. A reset mid-transfer drops Req at the next edge; the in-flight word is abandoned.
- Start with Capturing=0: latch BaseAddr into wr_addr and CaptureLen into len; clear in_cnt, out_cnt and Overflow; set Capturing=1 next cycle. If CaptureLen=0, pulse Done one cycle after Start and leave Capturing at 0.
- Push: SampleValid & Capturing & in_cnt<len & FillLevel<FIFO_DEPTH writes SampleData and increments in_cnt. If SampleValid & Capturing & in_cnt<len & full, set Overflow, drop the sample, and still increment in_cnt so the capture length stays bounded.
- Full test uses the pre-edge occupancy. A push at full is rejected even if a pop happens in the same cycle.
- Simultaneous push and pop below full: FillLevel unchanged.
- FIFO is first-word-fall-through: the head is visible combinationally to the writer.
- Writer FSM:
  - W_IDLE: if FIFO not empty and Busy=0, register DataIn<=head, Address<=wr_addr, Req<=1, pop, go to W_REQ.
  - W_REQ: hold Req, Address and DataIn stable. On Ack=1, set Req<=0, wr_addr<=wr_addr+1 (mod 2^ADDR_W, so 0x3FFFFF wraps to 0), out_cnt<=out_cnt+1, go to W_WAIT.
  - W_WAIT: when Busy=0, go to W_IDLE.
  - Any unused encoding goes to W_IDLE with Req=0.
- Req is never raised while Busy=1. It is raised at most once per FIFO word.
- Minimum cadence is one word per 3 cycles, plus controller Busy time.
- Completion: when out_cnt==len (dropped samples count as written) and Capturing=1 and the FIFO is empty, pulse Done for one cycle and clear Capturing.
- Start pulses while Capturing=1 are ignored. SampleValid while Capturing=0 is ignored.

Decomposition:
- Shared package adc_capture_pkg: writer state encodings (W_IDLE, W_REQ, W_WAIT), ADDR_W/DATA_W defaults, and the WnR write constant.
- One sub-module, sample_fifo: synchronous FWFT FIFO with push, pop, head, full, empty and level outputs.

Test Plan:
- Start with BaseAddr=0x000100 and CaptureLen=4, samples 0xA000..0xA003 one per cycle, controller model acks 1 cycle after Req -> writes to 0x100..0x103 with matching data; Done pulses once; Overflow=0.
- Hold Busy=1 for 40 cycles with FIFO_DEPTH=16 and 20 samples fed back-to-back -> FillLevel saturates at 16, Overflow=1, Req stays low while Busy=1, Done follows the 16th write.
- Start with BaseAddr=0x3FFFFE and CaptureLen=4 -> Address sequence 0x3FFFFE, 0x3FFFFF, 0x000000, 0x000001.
- Start with CaptureLen=0 -> Done pulse one cycle after Start; Req never asserted.
- Assert Reset while in W_REQ with Req=1 -> next cycle Req=0, FillLevel=0, Capturing=0, Overflow=0.
- Pulse Start a second time mid-capture with a different BaseAddr -> ignored; addresses continue from the original sequence.
